// File: rtl/left_barrel_rotator_pipe_8bits.sv
// Three-stage pipelined 8-bit left rotator / logical left shifter with valid/ready flow control.
// Each stage applies one binary weight of the shift amount (1, 2, then 4).
module left_barrel_rotator_pipe_8bits #(
   parameter int N  = 8,
   parameter int SW = 3
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  D,
   input  logic [SW-1:0] s,
   input  logic          mode,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  Q
);

   // One conditional step: rotate by k (m=0) or shift with zero fill (m=1).
   function automatic logic [N-1:0] step(input logic [N-1:0] x,
                                         input int unsigned  k,
                                         input logic         en,
                                         input logic         m);
      logic [N-1:0] r;
      r = x;
      if (en) begin
         if (m)
            r = x << k;
         else
            r = (x << k) | (x >> (N - k));
      end
      return r;
   endfunction

   logic          v1, v2, v3;
   logic [N-1:0]  d1, d2, d3;
   logic [SW-2:0] sh1;
   logic [SW-3:0] sh2;
   logic          m1, m2;
   logic          rdy1, rdy2, rdy3;

   // A stage may take new data when it is empty or its contents move on this edge.
   assign rdy3     = !v3 || out_ready;
   assign rdy2     = !v2 || rdy3;
   assign rdy1     = !v1 || rdy2;
   assign in_ready = rdy1;

   assign out_valid = v3;
   assign Q         = d3;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v1  <= 1'b0;
         d1  <= '0;
         sh1 <= '0;
         m1  <= 1'b0;
      end else if (rdy1) begin
         v1 <= in_valid;
         if (in_valid) begin
            d1  <= step(D, 1, s[0], mode);
            sh1 <= s[SW-1:1];
            m1  <= mode;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v2  <= 1'b0;
         d2  <= '0;
         sh2 <= '0;
         m2  <= 1'b0;
      end else if (rdy2) begin
         v2 <= v1;
         if (v1) begin
            d2  <= step(d1, 2, sh1[0], m1);
            sh2 <= sh1[SW-2:1];
            m2  <= m1;
         end
      end
   end

   // Mode and the last shift bit are consumed here, so only data reaches the output stage.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v3 <= 1'b0;
         d3 <= '0;
      end else if (rdy3) begin
         v3 <= v2;
         if (v2)
            d3 <= step(d2, 4, sh2[0], m2);
      end
   end

endmodule

// File: tb/tb_left_barrel_rotator_pipe_8bits.sv
// Directed-vector and scoreboard bench for left_barrel_rotator_pipe_8bits.
// Inputs change 1 time unit after the rising edge; the monitor samples on the falling edge.
module tb_left_barrel_rotator_pipe_8bits;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] D;
   logic [2:0] s;
   logic       mode;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] Q;

   always #5 clk = ~clk;

   left_barrel_rotator_pipe_8bits #(.N(8), .SW(3)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .D         (D),
      .s         (s),
      .mode      (mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Q         (Q)
   );

   typedef struct {
      logic [7:0] d;
      logic [2:0] s;
      logic       m;
      logic [7:0] q;
   } vec_t;

   int         checks = 0;
   int         failures = 0;
   int         out_count = 0;
   logic [7:0] exp_q[$];
   logic       prev_stall;
   logic [7:0] prev_q;
   vec_t       vecs[14];

   function automatic logic [7:0] ref_q(input logic [7:0] d, input logic [2:0] sh, input logic m);
      logic [15:0] wide;
      wide = {8'h00, d} << sh;
      return m ? wide[7:0] : (wide[7:0] | wide[15:8]);
   endfunction

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: an input or output handshake seen on the falling edge completes at the next rising edge.
   initial begin
      prev_stall = 1'b0;
      prev_q     = 8'h00;
      forever begin
         @(negedge clk or negedge reset_n);
         if (!reset_n) begin
            exp_q.delete();
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check_output("stall_valid", {31'b0, out_valid}, 32'd1);
               check_output("stall_q", {24'b0, Q}, {24'b0, prev_q});
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("[TB] FAIL sb_extra: got result %0h with no outstanding input", Q);
               end else begin
                  check_output("sb_q", {24'b0, Q}, {24'b0, exp_q.pop_front()});
                  out_count++;
               end
            end
            if (in_valid && in_ready)
               exp_q.push_back(ref_q(D, s, mode));
            prev_stall = out_valid && !out_ready;
            prev_q     = Q;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int gaps;
      int not_ready;
      int k;
      int seen;

      vecs[0]  = '{8'h81, 3'd1, 1'b0, 8'h03};
      vecs[1]  = '{8'h01, 3'd7, 1'b0, 8'h80};
      vecs[2]  = '{8'hFF, 3'd4, 1'b1, 8'hF0};
      vecs[3]  = '{8'hA5, 3'd0, 1'b1, 8'hA5};
      vecs[4]  = '{8'hA5, 3'd0, 1'b0, 8'hA5};
      vecs[5]  = '{8'h80, 3'd1, 1'b1, 8'h00};
      vecs[6]  = '{8'h80, 3'd1, 1'b0, 8'h01};
      vecs[7]  = '{8'h96, 3'd3, 1'b0, 8'hB4};
      vecs[8]  = '{8'h96, 3'd3, 1'b1, 8'hB0};
      vecs[9]  = '{8'h0F, 3'd4, 1'b0, 8'hF0};
      vecs[10] = '{8'hF0, 3'd4, 1'b0, 8'h0F};
      vecs[11] = '{8'hC3, 3'd6, 1'b1, 8'hC0};
      vecs[12] = '{8'hC3, 3'd6, 1'b0, 8'hF0};
      vecs[13] = '{8'h01, 3'd7, 1'b1, 8'h80};

      // Reset holds everything at zero even with clock running and inputs offered.
      reset_n   = 1'b0;
      in_valid  = 1'b1;
      D         = 8'hFF;
      s         = 3'd3;
      mode      = 1'b0;
      out_ready = 1'b1;
      #27;
      check_output("reset_out_valid", {31'b0, out_valid}, 32'd0);
      check_output("reset_q", {24'b0, Q}, 32'h00);
      in_valid = 1'b0;
      @(posedge clk);
      #2;
      reset_n = 1'b1;
      tick();
      check_output("post_reset_in_ready", {31'b0, in_ready}, 32'd1);
      check_output("post_reset_out_valid", {31'b0, out_valid}, 32'd0);

      // Directed vectors, one at a time, checking exact 3-cycle latency.
      for (int i = 0; i < 14; i++) begin
         D        = vecs[i].d;
         s        = vecs[i].s;
         mode     = vecs[i].m;
         in_valid = 1'b1;
         check_output($sformatf("vec%0d_in_ready", i), {31'b0, in_ready}, 32'd1);
         tick();
         in_valid = 1'b0;
         check_output($sformatf("vec%0d_lat1", i), {31'b0, out_valid}, 32'd0);
         tick();
         check_output($sformatf("vec%0d_lat2", i), {31'b0, out_valid}, 32'd0);
         tick();
         check_output($sformatf("vec%0d_lat3_valid", i), {31'b0, out_valid}, 32'd1);
         check_output($sformatf("vec%0d_q", i), {24'b0, Q}, {24'b0, vecs[i].q});
         tick();
         check_output($sformatf("vec%0d_drained", i), {31'b0, out_valid}, 32'd0);
      end

      // Backpressure: three inputs fill the pipe, the fourth is refused until release.
      out_ready = 1'b0;
      s         = 3'd1;
      mode      = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         D        = 8'(i);
         in_valid = 1'b1;
         check_output($sformatf("bp_accept%0d", i), {31'b0, in_ready}, 32'd1);
         tick();
      end
      D = 8'h04;
      for (int i = 0; i < 3; i++) begin
         check_output("bp_full_in_ready", {31'b0, in_ready}, 32'd0);
         check_output("bp_hold_valid", {31'b0, out_valid}, 32'd1);
         check_output("bp_hold_q", {24'b0, Q}, 32'h02);
         tick();
      end
      out_ready = 1'b1;
      #1;
      check_output("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
      check_output("bp_out0", {24'b0, Q}, 32'h02);
      tick();
      in_valid = 1'b0;
      check_output("bp_out1", {24'b0, Q}, 32'h04);
      tick();
      check_output("bp_out2", {24'b0, Q}, 32'h06);
      tick();
      check_output("bp_out3_valid", {31'b0, out_valid}, 32'd1);
      check_output("bp_out3", {24'b0, Q}, 32'h08);
      tick();
      check_output("bp_empty", {31'b0, out_valid}, 32'd0);

      // Exhaustive back-to-back stream; the scoreboard checks every value and order.
      out_count = 0;
      gaps      = 0;
      not_ready = 0;
      k         = 0;
      out_ready = 1'b1;
      for (int m = 0; m < 2; m++) begin
         for (int sh = 0; sh < 8; sh++) begin
            for (int dd = 0; dd < 256; dd++) begin
               D        = 8'(dd);
               s        = 3'(sh);
               mode     = 1'(m);
               in_valid = 1'b1;
               if (!in_ready) not_ready++;
               tick();
               k++;
               if (k >= 3 && !out_valid) gaps++;
            end
         end
      end
      in_valid = 1'b0;
      tick();
      if (!out_valid) gaps++;
      tick();
      if (!out_valid) gaps++;
      tick();
      check_output("exh_not_ready", not_ready, 32'd0);
      check_output("exh_gaps", gaps, 32'd0);
      check_output("exh_count", out_count, 32'd4096);
      check_output("exh_drained", {31'b0, out_valid}, 32'd0);

      // Asynchronous reset with two results in flight; neither may reappear.
      out_count = 0;
      D         = 8'h11;
      s         = 3'd1;
      mode      = 1'b0;
      in_valid  = 1'b1;
      tick();
      D = 8'h22;
      tick();
      in_valid = 1'b0;
      tick();
      check_output("rst_pre_valid", {31'b0, out_valid}, 32'd1);
      check_output("rst_pre_q", {24'b0, Q}, 32'h22);
      #2;
      reset_n = 1'b0;
      #1;
      check_output("rst_async_valid", {31'b0, out_valid}, 32'd0);
      check_output("rst_async_q", {24'b0, Q}, 32'h00);
      @(posedge clk);
      #1;
      check_output("rst_hold_valid", {31'b0, out_valid}, 32'd0);
      #1;
      reset_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (out_valid) seen++;
      end
      check_output("rst_no_stale", seen, 32'd0);
      check_output("rst_no_stale_count", out_count, 32'd0);
      check_output("rst_in_ready", {31'b0, in_ready}, 32'd1);

      // Random valid/ready traffic; inputs also change while refused.
      out_count = 0;
      for (int i = 0; i < 10000; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 3) != 0);
         D         = 8'($urandom_range(0, 255));
         s         = 3'($urandom_range(0, 7));
         mode      = 1'($urandom_range(0, 1));
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 20 && (out_valid || exp_q.size() != 0); i++)
         tick();
      check_output("rand_queue_empty", exp_q.size(), 32'd0);
      check_output("rand_drained", {31'b0, out_valid}, 32'd0);
      check_output("rand_traffic", {31'b0, out_count > 1000}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/left_barrel_rotator_pipe_8bits.md
LEFT_BARREL_ROTATOR_PIPE_8BITS -- requirements
Module: left_barrel_rotator_pipe_8bits

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the data width; only N = 8 is supported.
REQ-002 The block SHALL have parameter SW, default 3, giving the shift-amount width (log2 N).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: D, s and mode are valid this cycle.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts an input this cycle.
REQ-007 The block SHALL have port D, input, N bits: operand.
REQ-008 The block SHALL have port s, input, SW bits: left shift amount, 0-7.
REQ-009 The block SHALL have port mode, input, 1 bit: 0 = rotate left, 1 = logical shift left with zero fill.
REQ-010 The block SHALL have port out_valid, output, 1 bit: Q holds a valid result.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the downstream consumer takes Q this cycle.
REQ-012 The block SHALL have port Q, output, N bits: result, driven directly from a register.

Function
REQ-013 An input transfer SHALL occur on a rising edge where in_valid and in_ready are both 1; an output transfer SHALL occur where out_valid and out_ready are both 1.
REQ-014 The datapath SHALL be three register stages, each with its own valid bit, and each stage SHALL carry data, the remaining shift bits and mode.
REQ-015 Stage 1 SHALL shift left by 1 when s[0]=1, stage 2 by 2 when s[1]=1, and stage 3 by 4 when s[2]=1; stage 3 SHALL drive Q and out_valid.
REQ-016 Rotate (mode=0) SHALL give Q = (D << s) | (D >> (N - s)), truncated to N bits.
REQ-017 Logical shift (mode=1) SHALL give Q = (D << s) truncated to N bits, with vacated LSBs set to 0.
REQ-018 s = 0 SHALL return Q = D in both modes.
REQ-019 Latency SHALL be exactly 3 cycles from input transfer to out_valid=1 when there is no backpressure.
REQ-020 Throughput SHALL be 1 result per cycle while out_ready=1.
REQ-021 Stage k SHALL advance when its downstream stage is empty or advancing; the stage ready signal SHALL be !valid_k OR ready_(k+1), with out_ready as ready for stage 3.
REQ-022 in_ready SHALL be the stage-1 ready signal; it is combinational from out_ready and the valid bits, with no path from in_valid.
REQ-023 While out_valid=1 and out_ready=0, Q and out_valid SHALL hold stable, and no stage SHALL overwrite valid data.
REQ-024 With all three stages full and out_ready=0, in_ready SHALL be 0; an input transfer in the same cycle as an output transfer SHALL be accepted with no bubble.
REQ-025 Results SHALL leave in acceptance order; none SHALL be dropped or duplicated.
REQ-026 When in_valid=1 and in_ready=0, the block SHALL ignore D, s and mode.
REQ-027 Empty stages SHALL hold their data registers; their valid bits SHALL be 0.

Reset
REQ-028 While reset_n=0, all valid bits SHALL be 0 and all data and shift registers SHALL be 0, regardless of clk; therefore out_valid=0 and Q=8'h00.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight results immediately; no stale result SHALL appear after release.
REQ-030 After reset release, in_ready SHALL be 1 and the first accepted input SHALL produce out_valid=1 exactly 3 cycles later.

Verification
REQ-031 Bench case: D=8'h81, s=1, mode=0, out_ready=1 -> Q=8'h03 with out_valid=1 exactly 3 cycles after acceptance.
REQ-032 Bench case: D=8'h01, s=7, mode=0 -> Q=8'h80; then D=8'hFF, s=4, mode=1 -> Q=8'hF0; then D=8'hA5, s=0, mode=1 -> Q=8'hA5.
REQ-033 Bench case: exhaustive D 0-255 and s 0-7, both modes, back-to-back with out_ready=1 -> every Q matches REQ-016/017, one result per cycle, in order.
REQ-034 Bench case: out_ready=0 while inputs 8'h01, 8'h02, 8'h03, 8'h04 (s=1) are offered -> three inputs accepted, in_ready=0 on the fourth, Q held at 8'h02; release out_ready -> outputs 8'h02, 8'h04, 8'h06, 8'h08 in order.
REQ-035 Bench case: reset_n pulled low between clock edges with 2 results in flight -> out_valid and Q go to 0 asynchronously; after release, neither in-flight result ever appears.
REQ-036 Bench case: random in_valid and out_ready toggling over 10k cycles -> the scoreboard SHALL see all results in order, with Q stable under stall.
